keypad_level_scanner: RTL

Scans a 4x4 matrix keypad and converts a debounced keypress into the 4-bit water-level code (0–15 m) that feeds the water-level display and pump path. It is the input-side counterpart of the dot-matrix display driver: the display drives rows and columns out, and this block drives rows out and reads columns back in. It sits between the keypad pins and the `water_level_int` input of the display/pump logic. It issues a one-cycle `key_valid` strobe per accepted press.

---
 rtl/keypad_level_scanner_if.sv | 29 ++
 rtl/keypad_level_scanner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_level_scanner_if.sv
// Keypad pin and water-level result bundle between the scanner and its neighbours.
interface keypad_level_scanner_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] water_level_int;
  logic       key_valid;
  logic       key_down;
  logic       multi_key;

  // Keypad/consumer side: drives columns, observes rows and results.
  modport master (
    output col_in,
    input  row_out,
    input  water_level_int,
    input  key_valid,
    input  key_down,
    input  multi_key
  );

  // Scanner side.
  modport slave (
    input  col_in,
    output row_out,
    output water_level_int,
    output key_valid,
    output key_down,
    output multi_key
  );
endinterface

// File: rtl/keypad_level_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce producing a 4-bit water-level code.
module keypad_level_scanner #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_level_scanner_if.slave kp
);
  localparam int unsigned          DWELL_W    = $clog2(SCAN_DIV);
  localparam int unsigned          CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]     CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} result_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_ACCEPT, ST_HELD} state_e;

  logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         row_q, row_d;
  logic [3:0]         row_out_q, row_out_d;
  logic [1:0]         hits_q, hits_d;
  logic [3:0]         first_q, first_d;
  logic               scan_done_q, scan_done_d;
  result_e            result_q, result_d;
  logic [3:0]         res_code_q, res_code_d;
  logic               multi_key_q, multi_key_d;
  state_e             state_q, state_d;
  logic [3:0]         cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rel_q, rel_d;
  logic [3:0]         level_q, level_d;
  logic               key_valid_q, key_valid_d;
  logic               key_down_q, key_down_d;

  logic [1:0]         total;
  logic [3:0]         code;

  // Synchronizer, row sequencer and per-scan hit accumulator.
  always_comb begin
    sync1_d     = kp.col_in;
    sync2_d     = sync1_q;
    dwell_d     = dwell_q;
    row_d       = row_q;
    row_out_d   = row_out_q;
    hits_d      = hits_q;
    first_d     = first_q;
    scan_done_d = 1'b0;
    result_d    = result_q;
    res_code_d  = res_code_q;
    multi_key_d = multi_key_q;
    total       = hits_q;
    code        = first_q;

    // Fold this row's low columns into the running count; lowest column wins first-hit.
    for (int j = 0; j < 4; j++) begin
      if (!sync2_q[j]) begin
        if (total == 2'd0) code = {row_q, 2'(j)};
        if (total != 2'd2) total = total + 2'd1;
      end
    end

    if (dwell_q == DWELL_LAST) begin
      dwell_d   = '0;
      row_d     = row_q + 2'd1;
      row_out_d = ~(4'b0001 << row_d);
      if (row_q == 2'd3) begin
        scan_done_d = 1'b1;
        res_code_d  = code;
        multi_key_d = (total == 2'd2);
        result_d    = (total == 2'd0) ? RES_NONE :
                      (total == 2'd1) ? RES_SINGLE : RES_MULTI;
        hits_d      = '0;
        first_d     = '0;
      end else begin
        hits_d  = total;
        first_d = code;
      end
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end
  end

  // Press/release debounce FSM, advancing only on scan results.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    level_d     = level_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    case (state_q)
      ST_IDLE: begin
        if (scan_done_q && (result_q == RES_SINGLE)) begin
          cand_d  = res_code_q;
          cnt_d   = CNT_ONE;
          state_d = (DEBOUNCE_SCANS == 1) ? ST_ACCEPT : ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (scan_done_q) begin
          if ((result_q == RES_SINGLE) && (res_code_q == cand_q)) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_TARGET) state_d = ST_ACCEPT;
          end else if (result_q == RES_SINGLE) begin
            cand_d = res_code_q;
            cnt_d  = CNT_ONE;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ACCEPT: begin
        level_d     = cand_q;
        key_valid_d = 1'b1;
        key_down_d  = 1'b1;
        rel_d       = '0;
        state_d     = ST_HELD;
      end
      ST_HELD: begin
        if (scan_done_q) begin
          if (result_q == RES_NONE) begin
            rel_d = rel_q + CNT_ONE;
            if (rel_d == CNT_TARGET) begin
              key_down_d = 1'b0;
              state_d    = ST_IDLE;
            end
          end else begin
            rel_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      dwell_q     <= '0;
      row_q       <= 2'd0;
      row_out_q   <= 4'b1110;
      hits_q      <= 2'd0;
      first_q     <= 4'd0;
      scan_done_q <= 1'b0;
      result_q    <= RES_NONE;
      res_code_q  <= 4'd0;
      multi_key_q <= 1'b0;
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      rel_q       <= '0;
      level_q     <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      dwell_q     <= dwell_d;
      row_q       <= row_d;
      row_out_q   <= row_out_d;
      hits_q      <= hits_d;
      first_q     <= first_d;
      scan_done_q <= scan_done_d;
      result_q    <= result_d;
      res_code_q  <= res_code_d;
      multi_key_q <= multi_key_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      level_q     <= level_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign kp.row_out         = row_out_q;
  assign kp.water_level_int = level_q;
  assign kp.key_valid       = key_valid_q;
  assign kp.key_down        = key_down_q;
  assign kp.multi_key       = multi_key_q;
endmodule
